step_dir_gen: RTL and testbench
===============================

STEP_DIR_GEN -- requirements
Module: step_dir_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the step count.
REQ-002 SHALL have parameter PER_W, default 16, width of the step period in clk cycles.
REQ-003 SHALL have parameter DIR_SETUP, default 4, clk cycles of dir-to-first-step setup (minimum 1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  move command offered.
REQ-007 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-008 SHALL have port cmd_dir  input  1  direction, 1 = forward (driver counts up).
REQ-009 SHALL have port cmd_steps  input  CNT_W  number of step pulses to emit.
REQ-010 SHALL have port cmd_period  input  PER_W  cycles per step (high + low).
REQ-011 SHALL have port cmd_pulse_w  input  8  step high time in cycles.
REQ-012 SHALL have port abort  input  1  stop the move early.
REQ-013 SHALL have port step  output  1  registered step pulse to the driver's step input.
REQ-014 SHALL have port dir  output  1  registered direction to the driver's dir input.
REQ-015 SHALL have port busy  output  1  move in progress.
REQ-016 SHALL have port done  output  1  one-cycle pulse at move end.
REQ-017 SHALL have port steps_left  output  CNT_W  remaining pulses in the current move.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, HIGH, LOW; cmd_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-019 SHALL accept a command on a clk edge where cmd_valid && cmd_ready, and SHALL latch all cmd_* fields at that edge.
REQ-020 SHALL treat cmd_pulse_w = 0 as 1, and SHALL clamp the effective period to max(cmd_period, pw_eff + 1) so the low phase is at least 1 cycle.
REQ-021 On accept with cmd_steps = 0: stay IDLE, leave dir unchanged, assert done for the next cycle only.
REQ-022 On accept with cmd_steps > 0: the next cycle shows dir = cmd_dir, busy = 1, steps_left = cmd_steps, and state SETUP.
REQ-023 SETUP SHALL last exactly DIR_SETUP cycles with step = 0, then enter HIGH.
REQ-024 HIGH SHALL last pw_eff cycles with step = 1; LOW SHALL last (period_eff - pw_eff) cycles with step = 0; each step occupies exactly period_eff cycles.
REQ-025 steps_left SHALL decrement by 1 on the HIGH->LOW transition and never wrap below 0.
REQ-026 At the end of LOW with steps_left = 0: enter IDLE and pulse done for one cycle, with busy = 0 in that same cycle. Otherwise re-enter HIGH; there is no SETUP between steps.
REQ-027 dir SHALL be constant from the first SETUP cycle through the last LOW cycle, and SHALL hold its value in IDLE.
REQ-028 abort in SETUP or LOW: next cycle is IDLE with step = 0, done pulsed, and steps_left holding the remaining count.
REQ-029 abort in HIGH: it is latched, the high phase completes (no runt pulse) and steps_left decrements, then IDLE with done pulsed; no LOW phase follows.
REQ-030 abort in IDLE SHALL be ignored; abort asserted in the same cycle as an accept SHALL be ignored for that cycle.
REQ-031 step SHALL never be high in SETUP, LOW or IDLE, and SHALL change only on clk edges (glitch-free register output).

Reset
REQ-032 While reset = 1 at a clk edge: state is IDLE, step = 0, dir = 0, busy = 0, done = 0, steps_left = 0, cmd_ready = 1 from the next cycle, and any latched abort is cleared.
REQ-033 Reset SHALL take priority over cmd_valid and abort. A reset during HIGH SHALL drop step to 0 on the next cycle.

Verification
REQ-034 Accept at T with steps=3, period=10, pw=2, dir=1, DIR_SETUP=4 -> dir=1 at T+1; step rises at T+5, T+15, T+25, each high 2 cycles; done at T+35; busy low at T+35.
REQ-035 Accept with steps=0 -> done single-cycle at T+1; busy, step and dir unchanged.
REQ-036 Accept with pw=0, period=1 -> pw_eff=1, period_eff=2; step toggles 1,0,1,0 per cycle for the commanded count.
REQ-037 steps=5, abort during the 2nd HIGH -> that pulse completes full width, steps_left=3, done pulsed, no 3rd pulse.
REQ-038 Reset asserted mid-LOW of a steps=100 move -> next cycle all outputs at reset values; a new command is then accepted normally.
REQ-039 Back-to-back commands with opposite dir and cmd_valid held high -> second accepted the cycle after done; dir changes only at the second accept+1; first step of the second move follows DIR_SETUP cycles after the dir change.

Source files
------------

// File: rtl/step_dir_gen.sv
// Step/dir pulse generator for a stepper driver.
// Emits a counted train of fixed-width step pulses after a dir setup delay.
module step_dir_gen #(
  parameter int CNT_W     = 16,
  parameter int PER_W     = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [PER_W-1:0] cmd_period,
  input  logic [7:0]       cmd_pulse_w,
  input  logic             abort,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  localparam int W0 = (PER_W > 9) ? PER_W : 9;
  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam int W  = (W0 > SW) ? W0 : SW;
  localparam logic [W-1:0] SETUP_N = W'(DIR_SETUP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW
  } state_t;

  state_t state;
  logic [W-1:0] cnt;
  logic [W-1:0] pw_q;
  logic [W-1:0] lo_q;
  logic         ab_q;

  logic [W-1:0] pw_eff;
  logic [W-1:0] per_ext;
  logic [W-1:0] per_eff;
  logic         accept;
  logic         last;

  always_comb begin
    pw_eff  = W'(cmd_pulse_w);
    if (cmd_pulse_w == 8'd0)
      pw_eff = W'(1);
    per_ext = W'(cmd_period);
    per_eff = per_ext;
    if (per_ext <= pw_eff)
      per_eff = pw_eff + W'(1);
  end

  assign accept    = cmd_valid && (state == IDLE);
  assign last      = (cnt == '0);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      pw_q       <= W'(1);
      lo_q       <= W'(1);
      ab_q       <= 1'b0;
      step       <= 1'b0;
      dir        <= 1'b0;
      done       <= 1'b0;
      steps_left <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          ab_q <= 1'b0;
          if (accept) begin
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              state      <= SETUP;
              cnt        <= SETUP_N;
              dir        <= cmd_dir;
              steps_left <= cmd_steps;
              pw_q       <= pw_eff;
              lo_q       <= per_eff - pw_eff;
            end
          end
        end
        SETUP: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (last) begin
            state <= HIGH;
            step  <= 1'b1;
            cnt   <= pw_q - W'(1);
          end else begin
            cnt <= cnt - W'(1);
          end
        end
        HIGH: begin
          ab_q <= ab_q | abort;
          if (last) begin
            step <= 1'b0;
            if (steps_left != '0)
              steps_left <= steps_left - CNT_W'(1);
            if (ab_q || abort) begin
              // pulse finished at full width; no low phase after abort
              state <= IDLE;
              done  <= 1'b1;
              ab_q  <= 1'b0;
            end else begin
              state <= LOW;
              cnt   <= lo_q - W'(1);
            end
          end else begin
            cnt <= cnt - W'(1);
          end
        end
        LOW: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b1;
          end else if (last) begin
            if (steps_left == '0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= HIGH;
              step  <= 1'b1;
              cnt   <= pw_q - W'(1);
            end
          end else begin
            cnt <= cnt - W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_dir_gen.sv
// Bench for step_dir_gen: directed and random moves checked
// against a cycle-index model of the step train.
module tb_step_dir_gen;

  localparam int DS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic [15:0] cmd_period;
  logic [7:0]  cmd_pulse_w;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;

  int checks   = 0;
  int failures = 0;

  int c_dir, c_n, c_per, c_pw;
  int x_dir, x_n, x_per, x_pw;
  int prev_dir = 0;
  int prev_sl  = 0;

  step_dir_gen #(
    .CNT_W(16), .PER_W(16), .DIR_SETUP(DS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .cmd_pulse_w(cmd_pulse_w),
    .abort      (abort),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int d, input int n, input int per,
                       input int pw);
    cmd_dir     = d[0];
    cmd_steps   = 16'(n);
    cmd_period  = 16'(per);
    cmd_pulse_w = 8'(pw);
  endtask

  task automatic start_cmd(input int d, input int n, input int per,
                           input int pw);
    c_dir = d; c_n = n; c_per = per; c_pw = pw;
    drive(d, n, per, pw);
    cmd_valid = 1'b1;
  endtask

  // remaining pulses seen in cycle k of a move (k=1 is first SETUP cycle)
  function automatic int sl_at(int k, int n, int pe, int pwe);
    int j;
    if (k <= DS) return n;
    j = k - DS - 1;
    return n - j / pe - ((j % pe) >= pwe ? 1 : 0);
  endfunction

  function automatic int pwe_of(int pw);
    return (pw == 0) ? 1 : pw;
  endfunction

  function automatic int pe_of(int per, int pw);
    return (per > pwe_of(pw)) ? per : pwe_of(pw) + 1;
  endfunction

  // command is already on the port; accept happens at the next edge
  task automatic run_move(input int ka, input bit hold);
    int d, n, pwe, pe, kend, ha, j, fin, e_step, e_sl, e_dir;
    d = c_dir; n = c_n;
    pwe = pwe_of(c_pw);
    pe  = pe_of(c_per, c_pw);
    ha  = 0;
    if (n == 0) kend = 1;
    else if (ka == 0) kend = DS + n * pe + 1;
    else if (ka <= DS) kend = ka + 1;
    else begin
      j = ka - DS - 1;
      if ((j % pe) < pwe) begin
        kend = DS + 1 + (j / pe) * pe + pwe;
        ha = 1;
      end else kend = ka + 1;
    end
    if (n == 0) fin = prev_sl;
    else fin = sl_at(kend - 1, n, pe, pwe) - ha;
    e_dir = (n == 0) ? prev_dir : d;
    for (int k = 1; k <= kend + (hold ? 0 : 1); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (hold) begin
          c_dir = x_dir; c_n = x_n; c_per = x_per; c_pw = x_pw;
          drive(x_dir, x_n, x_per, x_pw);
        end else cmd_valid = 1'b0;
      end
      abort = (k == ka);
      if (k < kend) begin
        j = k - DS - 1;
        e_step = (k > DS && (j % pe) < pwe) ? 1 : 0;
        e_sl = sl_at(k, n, pe, pwe);
        chk("step", step, e_step);
        chk("busy", busy, 1);
        chk("ready", cmd_ready, 0);
        chk("done", done, 0);
        chk("steps_left", steps_left, e_sl);
      end else begin
        chk("step_end", step, 0);
        chk("busy_end", busy, 0);
        chk("ready_end", cmd_ready, 1);
        chk("done_end", done, (k == kend) ? 1 : 0);
        chk("steps_left_end", steps_left, fin);
      end
      chk("dir", dir, e_dir);
    end
    prev_dir = e_dir;
    prev_sl  = fin;
  endtask

  initial begin
    int n, per, pw, ka, kn;
    reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sl", steps_left, 0);
    chk("rst_ready", cmd_ready, 1);

    abort = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_done", done, 0);

    start_cmd(1, 3, 10, 2); run_move(0, 0);
    start_cmd(0, 0, 5, 1);  run_move(0, 0);
    start_cmd(1, 4, 1, 0);  run_move(0, 0);
    start_cmd(1, 5, 10, 2); run_move(DS + 12, 0);
    start_cmd(0, 3, 6, 2);  run_move(2, 0);
    start_cmd(1, 3, 6, 2);  run_move(DS + 5, 0);
    start_cmd(0, 2, 3, 7);  run_move(DS + 3, 0);
    start_cmd(1, 2, 4, 1);
    abort = 1'b1;
    run_move(0, 0);

    start_cmd(1, 2, 4, 1);
    x_dir = 0; x_n = 2; x_per = 5; x_pw = 2;
    run_move(0, 1);
    run_move(0, 0);

    start_cmd(1, 100, 6, 2);
    for (int k = 1; k <= DS + 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) cmd_valid = 1'b0;
    end
    chk("pre_rst_step", step, 0);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    start_cmd(1, 3, 5, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_step", step, 0);
    chk("mid_rst_dir", dir, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sl", steps_left, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    prev_dir = 0; prev_sl = 0;
    run_move(0, 0);

    for (int r = 0; r < 12; r++) begin
      n   = $urandom_range(0, 4);
      per = $urandom_range(0, 12);
      pw  = $urandom_range(0, 5);
      ka  = 0;
      kn  = DS + n * pe_of(per, pw) + 1;
      if (n > 0 && $urandom_range(0, 1) == 1)
        ka = $urandom_range(1, kn - 1);
      start_cmd($urandom_range(0, 1), n, per, pw);
      run_move(ka, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
